pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAM_TIMEOUT, 16, max cycles in REQ before forced completion.
REQ-002 Parameter CNT_W, 16, stall counter width.
REQ-003 clk  in  1  single clock; all state on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 fs_fetch_ok  in  1  IF instruction word available.
REQ-006 ds_load_use  in  1  ID operand depends on load in EX.
REQ-007 es_br_taken  in  1  branch/jump resolved taken in EX.
REQ-008 ms_mem_req  in  1  MEM instruction accesses data RAM.
REQ-009 dram_ack  in  1  data RAM accepts/completes access.
REQ-010 dram_req  out  1  data RAM request.
REQ-011 fs_valid, ds_valid, es_valid, ms_valid, ws_valid  out  1 each  stage holds live instruction.
REQ-012 if_ready_go, id_ready_go, ex_ready_go, mem_ready_go  out  1 each  load enable for the following pipeline register.
REQ-013 br_flush  out  1  one-cycle kill of IF/ID.
REQ-014 dram_err  out  1  sticky timeout flag.
REQ-015 stall_cnt  out  CNT_W  saturating stall-cycle count.

Function
REQ-016 Internal go: IF=fs_fetch_ok; ID=!ds_load_use; EX=1; MEM=(!ms_mem_req) or FSM in DONE; WB=1.
REQ-017 allowin(WB)=1; allowin(X)=!X_valid | (go(X) & allowin(next)), purely combinational.
REQ-018 X_ready_go output = X_valid & go(X) & allowin(next) & !(br_flush for IF/ID).
REQ-019 Next-stage valid updates only when allowin(next): next_valid <= X_ready_go output; otherwise holds.
REQ-020 fs_valid SHALL go 1 the first cycle after reset release and remain 1 thereafter.
REQ-021 br_flush = es_valid & es_br_taken, combinational; that cycle ds_valid SHALL clear and IF/ID ready_go outputs SHALL be 0.
REQ-022 Flush and load-use in same cycle: flush wins; ID instruction discarded, no stall counted for it.
REQ-023 DRAM FSM states IDLE, REQ, DONE; IDLE->REQ when ms_valid & ms_mem_req; REQ->DONE on dram_ack or timeout; DONE->IDLE when mem_ready_go.
REQ-024 dram_req = 1 exactly in REQ; held stable until dram_ack.
REQ-025 Timeout counter clears on REQ entry, increments per REQ cycle; reaching DRAM_TIMEOUT-1 without ack forces DONE and sets dram_err until reset.
REQ-026 dram_ack in IDLE or DONE SHALL be ignored.
REQ-027 Minimum MEM occupancy for ms_mem_req instruction = 3 cycles (IDLE, REQ with ack, DONE); non-memory instruction = 1 cycle.
REQ-028 stall_cnt increments once per cycle when any stage valid & !go(X); saturates at all-ones, no wrap.

Reset
REQ-029 Assertion of rst SHALL immediately force all valids 0, all ready_go 0, dram_req 0, br_flush 0, dram_err 0, stall_cnt 0, FSM IDLE, timeout counter 0.
REQ-030 Reset during REQ SHALL drop dram_req without waiting for ack; pending access abandoned.

Structure
REQ-031 Package pipe_ctrl_pkg SHALL hold FSM state enum and default DRAM_TIMEOUT/CNT_W constants.
REQ-032 DRAM FSM plus timeout counter SHALL be sub-module pipe_dram_fsm; valid/allowin chain remains in pipe_ctrl.

Verification
REQ-033 Reset release, fs_fetch_ok=1, no hazards -> fs_valid at cycle 1, ws_valid at cycle 5, all ready_go 1 steady.
REQ-034 ds_load_use=1 for 1 cycle with es_valid -> id_ready_go=0 and if_ready_go=0 that cycle, ex/mem flow on, stall_cnt +1.
REQ-035 Load in MEM, dram_ack 2 cycles after dram_req rise -> mem_ready_go high 1 cycle after ack, upstream stalls, MEM held 4 cycles.
REQ-036 es_br_taken with ds_load_use same cycle -> br_flush=1, ds_valid 0 next cycle, no ID stall counted.
REQ-037 dram_ack never asserted, DRAM_TIMEOUT=16 -> dram_req high 16 cycles, then DONE, dram_err=1 sticky, pipeline resumes.
REQ-038 rst asserted mid-REQ -> dram_req 0 immediately, all valids 0; after release FSM IDLE and stall_cnt 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and defaults for the 5-stage pipeline controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_ctrl_pkg;

  // Data-RAM access sequencer states.
  typedef enum logic [1:0] {
    DRAM_IDLE = 2'd0,
    DRAM_REQ  = 2'd1,
    DRAM_DONE = 2'd2
  } dram_state_t;

  localparam int DEF_DRAM_TIMEOUT = 16;  // max REQ cycles before forced completion
  localparam int DEF_CNT_W        = 16;  // stall counter width

endpackage

// File: rtl/pipe_ctrl_if.sv
// Bundle of the pipeline controller's hazard inputs, stage enables and DRAM handshake.
// Latency: n/a (wires only).
// Backpressure: n/a; master = controller side, slave = datapath/RAM side.
// Ports: fs_fetch_ok/ds_load_use/es_br_taken/ms_mem_req/dram_ack into the controller;
//        dram_req, stage valids, ready_go enables, br_flush, dram_err, stall_cnt out of it.
interface pipe_ctrl_if #(
  parameter int CNT_W = pipe_ctrl_pkg::DEF_CNT_W
);
  logic             fs_fetch_ok;
  logic             ds_load_use;
  logic             es_br_taken;
  logic             ms_mem_req;
  logic             dram_ack;
  logic             dram_req;
  logic             fs_valid;
  logic             ds_valid;
  logic             es_valid;
  logic             ms_valid;
  logic             ws_valid;
  logic             if_ready_go;
  logic             id_ready_go;
  logic             ex_ready_go;
  logic             mem_ready_go;
  logic             br_flush;
  logic             dram_err;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    input  fs_fetch_ok, ds_load_use, es_br_taken, ms_mem_req, dram_ack,
    output dram_req, fs_valid, ds_valid, es_valid, ms_valid, ws_valid,
    output if_ready_go, id_ready_go, ex_ready_go, mem_ready_go,
    output br_flush, dram_err, stall_cnt
  );

  modport slave (
    output fs_fetch_ok, ds_load_use, es_br_taken, ms_mem_req, dram_ack,
    input  dram_req, fs_valid, ds_valid, es_valid, ms_valid, ws_valid,
    input  if_ready_go, id_ready_go, ex_ready_go, mem_ready_go,
    input  br_flush, dram_err, stall_cnt
  );
endinterface

// File: rtl/pipe_dram_fsm.sv
// Sequences one data-RAM access for the MEM stage, with a watchdog that forces completion.
// Latency: >=1 REQ cycle after the IDLE cycle; DONE lasts until MEM hands off (min 3 cycles total).
// Backpressure: dram_req held until dram_ack or timeout; DONE held until mem_ready_go.
// Ports: clk, rst (async active-low); ms_valid/ms_mem_req start an access, dram_ack ends it,
//        mem_ready_go releases DONE; state, dram_req, dram_err (sticky) are registered outputs.
module pipe_dram_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAM_TIMEOUT = DEF_DRAM_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ms_valid,
  input  logic        ms_mem_req,
  input  logic        mem_ready_go,
  input  logic        dram_ack,
  output dram_state_t state,
  output logic        dram_req,
  output logic        dram_err
);

  localparam int TO_W = (DRAM_TIMEOUT > 2) ? $clog2(DRAM_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(DRAM_TIMEOUT - 1);
  localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

  logic [TO_W-1:0] to_cnt;

  // dram_ack only matters in REQ; in IDLE/DONE it is deliberately not looked at.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= DRAM_IDLE;
      dram_req <= 1'b0;
      dram_err <= 1'b0;
      to_cnt   <= '0;
    end else begin
      case (state)
        DRAM_IDLE: begin
          if (ms_valid && ms_mem_req) begin
            state    <= DRAM_REQ;
            dram_req <= 1'b1;
            to_cnt   <= '0;
          end
        end
        DRAM_REQ: begin
          if (dram_ack) begin
            state    <= DRAM_DONE;
            dram_req <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            // Give up on the RAM so the pipeline keeps moving; the error stays latched.
            state    <= DRAM_DONE;
            dram_req <= 1'b0;
            dram_err <= 1'b1;
          end else begin
            to_cnt <= to_cnt + TO_ONE;
          end
        end
        DRAM_DONE: begin
          if (mem_ready_go) begin
            state <= DRAM_IDLE;
          end
        end
        default: begin
          state    <= DRAM_IDLE;
          dram_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Valid/allowin controller for an IF-ID-EX-MEM-WB pipeline with load-use, branch-flush and DRAM stalls.
// Latency: one stage per cycle when unstalled; first instruction reaches WB 5 cycles after reset release.
// Backpressure: allowin chains back combinationally from WB; a stalled stage freezes everything upstream.
// Ports: clk, rst (async active-low); bus (pipe_ctrl_if.master) carries hazard inputs, stage valids,
//        ready_go load enables, br_flush, DRAM handshake, dram_err and the saturating stall_cnt.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAM_TIMEOUT = DEF_DRAM_TIMEOUT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic      clk,
  input  logic      rst,
  pipe_ctrl_if.master bus
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dram_state_t      dram_state;
  logic             dram_req;
  logic             dram_err;
  logic             fs_valid_q, ds_valid_q, es_valid_q, ms_valid_q, ws_valid_q;
  logic             fs_go, ds_go, ms_go;
  logic             ws_allowin, ms_allowin, es_allowin, ds_allowin;
  logic             if_rg, id_rg, ex_rg, mem_rg;
  logic             br_flush;
  logic             stall_now;
  logic [CNT_W-1:0] stall_cnt_q;

  // Per-stage go; EX and WB always complete in one cycle.
  assign fs_go = bus.fs_fetch_ok;
  assign ds_go = !bus.ds_load_use;
  assign ms_go = !bus.ms_mem_req || (dram_state == DRAM_DONE);

  assign ws_allowin = 1'b1;
  assign ms_allowin = !ms_valid_q || (ms_go && ws_allowin);
  assign es_allowin = !es_valid_q || ms_allowin;
  assign ds_allowin = !ds_valid_q || (ds_go && es_allowin);

  assign br_flush = es_valid_q && bus.es_br_taken;

  // A taken branch kills whatever is in IF and ID, so neither may hand forward.
  assign if_rg  = fs_valid_q && fs_go && ds_allowin && !br_flush;
  assign id_rg  = ds_valid_q && ds_go && es_allowin && !br_flush;
  assign ex_rg  = es_valid_q && ms_allowin;
  assign mem_rg = ms_valid_q && ms_go && ws_allowin;

  // A load-use hazard on an instruction being flushed is not a real stall.
  assign stall_now = (fs_valid_q && !fs_go)
                  || (ds_valid_q && !ds_go && !br_flush)
                  || (ms_valid_q && !ms_go);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fs_valid_q  <= 1'b0;
      ds_valid_q  <= 1'b0;
      es_valid_q  <= 1'b0;
      ms_valid_q  <= 1'b0;
      ws_valid_q  <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      // The fetch stage always holds a (possibly not yet ready) instruction.
      fs_valid_q <= 1'b1;
      if (br_flush) begin
        ds_valid_q <= 1'b0;
      end else if (ds_allowin) begin
        ds_valid_q <= if_rg;
      end
      if (es_allowin) es_valid_q <= id_rg;
      if (ms_allowin) ms_valid_q <= ex_rg;
      if (ws_allowin) ws_valid_q <= mem_rg;
      if (stall_now && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
    end
  end

  pipe_dram_fsm #(
    .DRAM_TIMEOUT(DRAM_TIMEOUT)
  ) u_dram_fsm (
    .clk          (clk),
    .rst          (rst),
    .ms_valid     (ms_valid_q),
    .ms_mem_req   (bus.ms_mem_req),
    .mem_ready_go (mem_rg),
    .dram_ack     (bus.dram_ack),
    .state        (dram_state),
    .dram_req     (dram_req),
    .dram_err     (dram_err)
  );

  assign bus.dram_req     = dram_req;
  assign bus.dram_err     = dram_err;
  assign bus.fs_valid     = fs_valid_q;
  assign bus.ds_valid     = ds_valid_q;
  assign bus.es_valid     = es_valid_q;
  assign bus.ms_valid     = ms_valid_q;
  assign bus.ws_valid     = ws_valid_q;
  assign bus.if_ready_go  = if_rg;
  assign bus.id_ready_go  = id_rg;
  assign bus.ex_ready_go  = ex_rg;
  assign bus.mem_ready_go = mem_rg;
  assign bus.br_flush     = br_flush;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed scenarios for pipe_ctrl; per-cycle expectations queued with the stimulus and
// compared 1 ns after the driving (falling) edge, well away from the rising edge.
module tb_pipe_ctrl;

  localparam int TO = 16;
  localparam int CW = 5;   // narrow counter so saturation is reachable

  typedef enum int {
    SG_FS, SG_DS, SG_ES, SG_MS, SG_WS,
    SG_IFRG, SG_IDRG, SG_EXRG, SG_MEMRG,
    SG_FLUSH, SG_DREQ, SG_ERR, SG_STALL
  } sig_e;

  typedef struct {
    string tag;
    sig_e  sig;
    int    val;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pipe_ctrl_if #(.CNT_W(CW)) bus ();

  pipe_ctrl #(
    .DRAM_TIMEOUT(TO),
    .CNT_W       (CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  function automatic int obs(input sig_e s);
    int v;
    v = -1;
    case (s)
      SG_FS:    v = int'(bus.fs_valid);
      SG_DS:    v = int'(bus.ds_valid);
      SG_ES:    v = int'(bus.es_valid);
      SG_MS:    v = int'(bus.ms_valid);
      SG_WS:    v = int'(bus.ws_valid);
      SG_IFRG:  v = int'(bus.if_ready_go);
      SG_IDRG:  v = int'(bus.id_ready_go);
      SG_EXRG:  v = int'(bus.ex_ready_go);
      SG_MEMRG: v = int'(bus.mem_ready_go);
      SG_FLUSH: v = int'(bus.br_flush);
      SG_DREQ:  v = int'(bus.dram_req);
      SG_ERR:   v = int'(bus.dram_err);
      SG_STALL: v = int'(bus.stall_cnt);
      default:  v = -1;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, act, req);
    end
  endtask

  task automatic expect_sig(input string tag, input sig_e s, input int v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic expect_all_zero(input string tag);
    for (int k = 0; k <= int'(SG_STALL); k++) begin
      expect_sig($sformatf("%s_%0d", tag, k), sig_e'(k), 0);
    end
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, obs(e.sig), e.val);
    end
  endtask

  task automatic step(input logic fok, input logic lu, input logic br,
                      input logic mreq, input logic ack);
    @(negedge clk);
    bus.fs_fetch_ok = fok;
    bus.ds_load_use = lu;
    bus.es_br_taken = br;
    bus.ms_mem_req  = mreq;
    bus.dram_ack    = ack;
    #1;
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000 ns");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst             = 1'b1;
    bus.fs_fetch_ok = 1'b1;
    bus.ds_load_use = 1'b0;
    bus.es_br_taken = 1'b0;
    bus.ms_mem_req  = 1'b0;
    bus.dram_ack    = 1'b0;
    #2 rst = 1'b0;
    expect_all_zero("rst");
    #1 drain();
    repeat (2) @(posedge clk);
    expect_all_zero("rst_hold");
    @(negedge clk);
    #1 drain();

    // Release: nothing valid yet in the release cycle.
    expect_sig("c0_fs", SG_FS, 0);
    expect_sig("c0_ifrg", SG_IFRG, 0);
    @(negedge clk);
    rst = 1'b1;
    #1 drain();

    // Fill: stage k becomes valid k cycles after release; ack in IDLE at the end.
    for (int i = 1; i <= 6; i++) begin
      expect_sig($sformatf("fill%0d_fs", i), SG_FS, 1);
      expect_sig($sformatf("fill%0d_ds", i), SG_DS, (i >= 2) ? 1 : 0);
      expect_sig($sformatf("fill%0d_es", i), SG_ES, (i >= 3) ? 1 : 0);
      expect_sig($sformatf("fill%0d_ms", i), SG_MS, (i >= 4) ? 1 : 0);
      expect_sig($sformatf("fill%0d_ws", i), SG_WS, (i >= 5) ? 1 : 0);
      expect_sig($sformatf("fill%0d_ifrg", i), SG_IFRG, 1);
      expect_sig($sformatf("fill%0d_idrg", i), SG_IDRG, (i >= 2) ? 1 : 0);
      expect_sig($sformatf("fill%0d_exrg", i), SG_EXRG, (i >= 3) ? 1 : 0);
      expect_sig($sformatf("fill%0d_memrg", i), SG_MEMRG, (i >= 4) ? 1 : 0);
      expect_sig($sformatf("fill%0d_stall", i), SG_STALL, 0);
      step(1'b1, 1'b0, 1'b0, 1'b0, (i == 6) ? 1'b1 : 1'b0);
    end
    expect_sig("ack_idle_dreq", SG_DREQ, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Single-cycle load-use hazard.
    expect_sig("lu_idrg", SG_IDRG, 0);
    expect_sig("lu_ifrg", SG_IFRG, 0);
    expect_sig("lu_exrg", SG_EXRG, 1);
    expect_sig("lu_memrg", SG_MEMRG, 1);
    expect_sig("lu_stall0", SG_STALL, 0);
    expect_sig("lu_flush", SG_FLUSH, 0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    expect_sig("lu1_es", SG_ES, 0);
    expect_sig("lu1_exrg", SG_EXRG, 0);
    expect_sig("lu1_idrg", SG_IDRG, 1);
    expect_sig("lu1_ds", SG_DS, 1);
    expect_sig("lu1_stall", SG_STALL, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("lu2_ms", SG_MS, 0);
    expect_sig("lu2_memrg", SG_MEMRG, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("lu3_ws", SG_WS, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("lu4_ms", SG_MS, 1);
    expect_sig("lu4_ws", SG_WS, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Taken branch together with load-use: flush wins, no stall counted.
    expect_sig("br_flush", SG_FLUSH, 1);
    expect_sig("br_ifrg", SG_IFRG, 0);
    expect_sig("br_idrg", SG_IDRG, 0);
    expect_sig("br_exrg", SG_EXRG, 1);
    expect_sig("br_ds", SG_DS, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    expect_sig("br1_ds", SG_DS, 0);
    expect_sig("br1_flush", SG_FLUSH, 0);
    expect_sig("br1_stall", SG_STALL, 1);
    expect_sig("br1_ifrg", SG_IFRG, 1);
    expect_sig("br1_idrg", SG_IDRG, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("br2_ds", SG_DS, 1);
    expect_sig("br2_es", SG_ES, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("br5_es", SG_ES, 1);
    expect_sig("br5_ms", SG_MS, 1);
    expect_sig("br5_ws", SG_WS, 1);
    expect_sig("br5_stall", SG_STALL, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Load in MEM, ack in the second dram_req cycle: MEM occupied 4 cycles.
    expect_sig("ld0_memrg", SG_MEMRG, 0);
    expect_sig("ld0_exrg", SG_EXRG, 0);
    expect_sig("ld0_idrg", SG_IDRG, 0);
    expect_sig("ld0_ifrg", SG_IFRG, 0);
    expect_sig("ld0_dreq", SG_DREQ, 0);
    expect_sig("ld0_stall", SG_STALL, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_sig("ld1_dreq", SG_DREQ, 1);
    expect_sig("ld1_ms", SG_MS, 1);
    expect_sig("ld1_ifrg", SG_IFRG, 0);
    expect_sig("ld1_ws", SG_WS, 0);
    expect_sig("ld1_stall", SG_STALL, 2);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_sig("ld2_dreq", SG_DREQ, 1);
    expect_sig("ld2_memrg", SG_MEMRG, 0);
    expect_sig("ld2_stall", SG_STALL, 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    expect_sig("ld3_dreq", SG_DREQ, 0);
    expect_sig("ld3_memrg", SG_MEMRG, 1);
    expect_sig("ld3_exrg", SG_EXRG, 1);
    expect_sig("ld3_ifrg", SG_IFRG, 1);
    expect_sig("ld3_stall", SG_STALL, 4);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_sig("ld4_ws", SG_WS, 1);
    expect_sig("ld4_ms", SG_MS, 1);
    expect_sig("ld4_dreq", SG_DREQ, 0);
    expect_sig("ld4_stall", SG_STALL, 4);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // No ack ever: 16 request cycles, then forced DONE with a sticky error.
    for (int i = 0; i <= 17; i++) begin
      expect_sig($sformatf("to%0d_dreq", i), SG_DREQ, (i >= 1 && i <= 16) ? 1 : 0);
      expect_sig($sformatf("to%0d_err", i), SG_ERR, (i == 17) ? 1 : 0);
      if (i == 17) begin
        expect_sig("to17_memrg", SG_MEMRG, 1);
        expect_sig("to17_stall", SG_STALL, 21);
      end
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    expect_sig("to18_ws", SG_WS, 1);
    expect_sig("to18_err", SG_ERR, 1);
    expect_sig("to18_dreq", SG_DREQ, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("to19_err", SG_ERR, 1);
    expect_sig("to19_memrg", SG_MEMRG, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Fetch starvation drives the 5-bit counter into saturation without wrapping.
    for (int j = 0; j <= 12; j++) begin
      expect_sig($sformatf("sat%0d_stall", j), SG_STALL, (21 + j > 31) ? 31 : 21 + j);
      if (j == 0) expect_sig("sat0_ifrg", SG_IFRG, 0);
      step((j < 12) ? 1'b0 : 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Refill, start an access, then reset in the middle of REQ.
    repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_sig("rq0_dreq", SG_DREQ, 0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_sig("rq1_dreq", SG_DREQ, 1);
    expect_sig("rq1_ms", SG_MS, 1);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    #2;
    rst             = 1'b0;
    bus.es_br_taken = 1'b1;
    expect_all_zero("rst_mid");
    #1 drain();
    @(negedge clk);
    rst             = 1'b1;
    bus.es_br_taken = 1'b0;
    bus.ms_mem_req  = 1'b0;
    bus.dram_ack    = 1'b1;
    expect_sig("rel_fs", SG_FS, 0);
    expect_sig("rel_dreq", SG_DREQ, 0);
    #1 drain();
    expect_sig("rel1_fs", SG_FS, 1);
    expect_sig("rel1_dreq", SG_DREQ, 0);
    expect_sig("rel1_stall", SG_STALL, 0);
    expect_sig("rel1_err", SG_ERR, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    expect_sig("rel2_ds", SG_DS, 1);
    expect_sig("rel2_dreq", SG_DREQ, 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
